// File: rtl/mid_cmp_seq.sv
// mid_cmp_seq: fault-simulation mid section. It holds one registered pattern
// that drives a fault-injected CUT and a fault-free CUT, and compares their
// registered outputs. It walks the fault list, applying PATS_PER_FAULT
// patterns to each fault, and reports per-fault detection and coverage counts.
// Build option: define MID_FAULT_DROP_EN to enable fault dropping. With it,
// a fault stops receiving patterns as soon as it is detected.
//
// state | meaning
// IDLE  | waiting for start
// APPLY | accepting patterns for the active fault
// DRAIN | two cycles letting in-flight patterns reach the comparator
// NEXT  | report the finished fault, then advance the list or finish
// DONE  | campaign complete, counts held until start or rst

// Fault-free CUT: small combinational function of the pattern.
module cut_ref #(
  parameter int IN_BITS  = 5,
  parameter int OUT_BITS = 2
) (
  input  logic [IN_BITS-1:0]  cut_in,
  output logic [OUT_BITS-1:0] cut_out
);
  assign cut_out = OUT_BITS'(cut_in ^ (cut_in >> 1));
endmodule

// Fault-injected CUT. Fault k flips output bit 0 only for the pattern
// {1, k}. Its fault list index is advanced by fil_inc and restarted by fil_rst.
module cut_faulty #(
  parameter int IN_BITS    = 5,
  parameter int OUT_BITS   = 2,
  parameter int NUM_FAULTS = 3
) (
  input  logic                clk,
  input  logic                fil_rst,
  input  logic                fil_inc,
  output logic                fil_end,
  input  logic [IN_BITS-1:0]  cut_in,
  output logic [OUT_BITS-1:0] cut_out
);
  localparam int FI_W = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1;
  localparam int TW   = IN_BITS - 1;

  logic [FI_W-1:0]     fidx_q;
  logic [OUT_BITS-1:0] good;
  logic                trig;

  cut_ref #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_good (.cut_in(cut_in), .cut_out(good));

  assign fil_end = (fidx_q == FI_W'(NUM_FAULTS - 1));
  assign trig    = cut_in[IN_BITS-1] && (cut_in[TW-1:0] == TW'(fidx_q));
  assign cut_out = good ^ OUT_BITS'(trig);

  // Fault list pointer: restart on fil_rst, step on fil_inc, stop at last fault.
  always_ff @(posedge clk) begin
    if (fil_rst)                  fidx_q <= '0;
    else if (fil_inc && !fil_end) fidx_q <= fidx_q + FI_W'(1);
  end
endmodule

module mid_cmp_seq #(
  parameter int IN_BITS        = 5,
  parameter int OUT_BITS       = 2,
  parameter int PATS_PER_FAULT = 16,
  parameter int FCNT_W         = 16,
  parameter int NUM_FAULTS     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_BITS-1:0]  TEST_IP,
  input  logic                pat_valid,
  output logic                pat_ready,
  output logic [OUT_BITS-1:0] CUT_OP,
  output logic [OUT_BITS-1:0] FF_OP,
  output logic                mismatch,
  output logic                rpt_valid,
  output logic [FCNT_W-1:0]   rpt_fault,
  output logic                rpt_det,
  output logic [FCNT_W-1:0]   fault_cnt,
  output logic [FCNT_W-1:0]   det_cnt,
  output logic                busy,
  output logic                done
);
  localparam int PC_W = (PATS_PER_FAULT > 1) ? $clog2(PATS_PER_FAULT) : 1;

  typedef enum logic [2:0] {IDLE, APPLY, DRAIN, NEXT, DONE} state_t;

  state_t              state_q, state_d;
  logic [IN_BITS-1:0]  in_reg_q;
  logic [OUT_BITS-1:0] cut_op_q, ff_op_q, cf_out, cr_out;
  logic [PC_W-1:0]     pat_cnt_q;
  logic [FCNT_W-1:0]   fault_idx_q, fault_cnt_q, det_cnt_q;
  logic                det_flag_q, drain_q, vld1_q, vld2_q;
  logic                start_acc, hs, last_pat, fil_rst, fil_inc, fil_end, det_now;

  cut_faulty #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .NUM_FAULTS(NUM_FAULTS)) u_cut_faulty (
    .clk(clk), .fil_rst(fil_rst), .fil_inc(fil_inc), .fil_end(fil_end),
    .cut_in(in_reg_q), .cut_out(cf_out)
  );
  cut_ref #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_cut_ref (.cut_in(in_reg_q), .cut_out(cr_out));

  assign start_acc = start && (state_q == IDLE || state_q == DONE);
  assign fil_rst   = rst || start_acc;
  assign last_pat  = (pat_cnt_q == PC_W'(PATS_PER_FAULT - 1));
  assign mismatch  = vld2_q && (cut_op_q != ff_op_q);
  assign det_now   = det_flag_q || mismatch;
  assign CUT_OP    = cut_op_q;
  assign FF_OP     = ff_op_q;
  assign fault_cnt = fault_cnt_q;
  assign det_cnt   = det_cnt_q;
  assign busy      = (state_q == APPLY) || (state_q == DRAIN) || (state_q == NEXT);
  assign done      = (state_q == DONE);

  // Next-state and per-cycle strobes.
  always_comb begin
    state_d   = state_q;
    pat_ready = 1'b0;
    rpt_valid = 1'b0;
    rpt_fault = '0;
    rpt_det   = 1'b0;
    fil_inc   = 1'b0;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = APPLY;
      APPLY: begin
        pat_ready = 1'b1;
`ifdef MID_FAULT_DROP_EN
        if (det_now) begin
          pat_ready = 1'b0;
          state_d   = DRAIN;
        end else if (pat_valid && last_pat) begin
          state_d = DRAIN;
        end
`else
        if (pat_valid && last_pat) state_d = DRAIN;
`endif
      end
      DRAIN: if (drain_q) state_d = NEXT;
      NEXT: begin
        rpt_valid = 1'b1;
        rpt_fault = fault_idx_q;
        rpt_det   = det_now;
        if (fil_end) begin
          state_d = DONE;
        end else begin
          fil_inc = 1'b1;
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
    hs = pat_valid && pat_ready;
  end

  // State, pattern pipeline, detection flag and coverage counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_reg_q    <= '0;
      cut_op_q    <= '0;
      ff_op_q     <= '0;
      vld1_q      <= 1'b0;
      vld2_q      <= 1'b0;
      drain_q     <= 1'b0;
      pat_cnt_q   <= '0;
      fault_idx_q <= '0;
      fault_cnt_q <= '0;
      det_cnt_q   <= '0;
      det_flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld1_q  <= hs;
      vld2_q  <= vld1_q;
      drain_q <= (state_q == DRAIN) && !drain_q;
      if (hs) in_reg_q <= TEST_IP;
      if (vld1_q) begin
        cut_op_q <= cf_out;
        ff_op_q  <= cr_out;
      end
      if (start_acc) begin
        pat_cnt_q   <= '0;
        fault_idx_q <= '0;
        fault_cnt_q <= '0;
        det_cnt_q   <= '0;
        det_flag_q  <= 1'b0;
      end else begin
        if (hs)       pat_cnt_q  <= pat_cnt_q + PC_W'(1);
        if (mismatch) det_flag_q <= 1'b1;
        if (state_q == NEXT) begin
          if (fault_cnt_q != '1)          fault_cnt_q <= fault_cnt_q + FCNT_W'(1);
          if (det_now && det_cnt_q != '1) det_cnt_q   <= det_cnt_q + FCNT_W'(1);
          if (!fil_end) begin
            fault_idx_q <= fault_idx_q + FCNT_W'(1);
            pat_cnt_q   <= '0;
            det_flag_q  <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mid_cmp_seq.sv
// Bench for mid_cmp_seq: five-fault list, 2-bit counters, scoreboarded compares.
module tb_mid_cmp_seq;
  localparam int IN_BITS = 5;
  localparam int OUT_BITS = 2;
  localparam int PPF = 16;
  localparam int FCNT_W = 2;
  localparam int NFLT = 5;
  localparam int SAT = (1 << FCNT_W) - 1;

  logic clk = 1'b0;
  logic rst, start, pat_valid;
  logic [IN_BITS-1:0] TEST_IP;
  logic pat_ready, mismatch, rpt_valid, rpt_det, busy, done;
  logic [OUT_BITS-1:0] CUT_OP, FF_OP;
  logic [FCNT_W-1:0] rpt_fault, fault_cnt, det_cnt;

  always #5 clk = ~clk;

  mid_cmp_seq #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .PATS_PER_FAULT(PPF),
                .FCNT_W(FCNT_W), .NUM_FAULTS(NFLT)) dut (
    .clk(clk), .rst(rst), .start(start), .TEST_IP(TEST_IP), .pat_valid(pat_valid),
    .pat_ready(pat_ready), .CUT_OP(CUT_OP), .FF_OP(FF_OP), .mismatch(mismatch),
    .rpt_valid(rpt_valid), .rpt_fault(rpt_fault), .rpt_det(rpt_det),
    .fault_cnt(fault_cnt), .det_cnt(det_cnt), .busy(busy), .done(done)
  );

  int n_vec = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         due;
    logic       mm;
    logic [1:0] cut;
    logic [1:0] ff;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   fnum = 0, hs_cnt = 0, first_det = -1, ndet = 0, nrpt = 0, ninc = 0, exp_cnt;
  logic det_acc = 1'b0;
  logic trig;

  function automatic logic [1:0] ref_fn(input logic [4:0] p);
    return p[1:0] ^ p[2:1];
  endfunction

  // Monitor: scoreboard of per-pattern compares plus per-fault report model.
  always @(negedge clk) begin
    cyc++;
    if (rst || (start && !busy)) begin
      sb.delete();
      fnum = 0; hs_cnt = 0; first_det = -1; det_acc = 1'b0;
      ndet = 0; nrpt = 0; ninc = 0;
    end else begin
      if (dut.fil_inc) ninc++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check_val("mismatch", 32'(mismatch), 32'(e.mm));
        check_val("ff_op", 32'(FF_OP), 32'(e.ff));
        check_val("cut_op", 32'(CUT_OP), 32'(e.cut));
        if (e.mm) det_acc = 1'b1;
      end else if (mismatch) begin
        check_val("mismatch_spurious", 32'(mismatch), 32'd0);
      end
      if (pat_valid && pat_ready) begin
        trig = TEST_IP[4] && (TEST_IP[3:0] == fnum[3:0]);
        if (trig && first_det < 0) first_det = hs_cnt;
        sb.push_back('{cyc + 2, trig, ref_fn(TEST_IP) ^ {1'b0, trig}, ref_fn(TEST_IP)});
        hs_cnt++;
      end
      if (rpt_valid) begin
        exp_cnt = PPF;
`ifdef MID_FAULT_DROP_EN
        if (first_det >= 0 && first_det + 2 < PPF) exp_cnt = first_det + 2;
`endif
        check_val("rpt_fault", 32'(rpt_fault), 32'(fnum % (SAT + 1)));
        check_val("rpt_det", 32'(rpt_det), 32'(det_acc));
        check_val("pats_per_fault", hs_cnt, exp_cnt);
        check_val("fault_cnt_pre", 32'(fault_cnt), (fnum > SAT) ? SAT : fnum);
        check_val("det_cnt_pre", 32'(det_cnt), (ndet > SAT) ? SAT : ndet);
        if (det_acc) ndet++;
        fnum++; nrpt++; hs_cnt = 0; first_det = -1; det_acc = 1'b0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_val(tag, {16'd0, pat_ready, CUT_OP, FF_OP, mismatch, rpt_valid, rpt_fault,
                    rpt_det, fault_cnt, det_cnt, busy, done}, 32'd0);
  endtask

  task automatic run_campaign(input logic [4:0] det_mask, input int det_pat, input bit toggle,
                              input int abort_fault, input int abort_pat, input int exp_det);
    bit aborted = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 4000 && !done && !aborted; c++) begin
      if (abort_fault >= 0 && fnum == abort_fault && hs_cnt == abort_pat) begin
        rst = 1'b1; pat_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        check_all_zero("abort_outputs_zero");
        for (int k = 0; k < 4; k++) begin
          @(posedge clk); #1;
          check_val("abort_no_report", {rpt_valid, busy}, 32'd0);
        end
        aborted = 1'b1;
      end else begin
        pat_valid = toggle ? (c % 2 == 1) : 1'b1;
        if (fnum < NFLT && det_mask[fnum] && hs_cnt == det_pat)
          TEST_IP = {1'b1, fnum[3:0]};
        else
          TEST_IP = {1'b0, 4'($urandom)};
        @(posedge clk); #1;
      end
    end
    pat_valid = 1'b0;
    if (!aborted) begin
      check_val("campaign_done", {busy, done}, 32'b01);
      check_val("reports", nrpt, NFLT);
      check_val("fil_inc_pulses", ninc, NFLT - 1);
      check_val("fault_cnt_final", 32'(fault_cnt), SAT);
      check_val("det_cnt_final", 32'(det_cnt), exp_det);
      check_val("pending_compares", sb.size(), 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pat_valid = 1'b0; TEST_IP = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("reset_outputs");
    // no detection
    run_campaign(5'b00000, 0, 1'b0, -1, 0, 0);
    // fault 1 detected by pattern 5
    run_campaign(5'b00010, 5, 1'b0, -1, 0, 1);
    // pat_valid toggling, no detection
    run_campaign(5'b00000, 0, 1'b1, -1, 0, 0);
    // detection on the last pattern of fault 3
    run_campaign(5'b01000, PPF - 1, 1'b0, -1, 0, 1);
    // abort mid-APPLY of fault 2, then restart
    run_campaign(5'b00000, 0, 1'b0, 2, 7, 0);
    run_campaign(5'b00000, 0, 1'b0, -1, 0, 0);
    // every fault detected: counters saturate, rpt_fault wraps
    run_campaign(5'b11111, 3, 1'b0, -1, 0, SAT);
    // start ignored while busy
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    pat_valid = 1'b1; TEST_IP = '0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_val("start_while_busy", {busy, 30'd0, done}, {1'b1, 31'd0});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
